// File: rtl/ucsbece154b_branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB plus gshare PHT of 2-bit counters.
// Prediction is combinational from PCF_i; training happens at resolve from Execute.
module ucsbece154b_branch_predictor #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             PCF_i,
  output logic                    BranchTakenF_o,
  output logic [31:0]             BTBtargetF_o,
  output logic [NUM_GHR_BITS-1:0] PHTindexF_o,
  input  logic [31:0]             PCE_i,
  input  logic [31:0]             PCTargetE_i,
  input  logic                    BranchE_i,
  input  logic                    JumpE_i,
  input  logic                    BranchTakenE_i,
  input  logic [NUM_GHR_BITS-1:0] PHTindexE_i
);

  localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int PHT_N = 1 << NUM_GHR_BITS;

  logic [NUM_BTB_ENTRIES-1:0]  valid_q;
  logic [NUM_BTB_ENTRIES-1:0]  jump_q;
  logic [NUM_BTB_ENTRIES-1:0]  branch_q;
  logic [TAG_W-1:0]            tag_q    [NUM_BTB_ENTRIES];
  logic [31:0]                 target_q [NUM_BTB_ENTRIES];
  logic [PHT_N-1:0][1:0]       pht_q;
  logic [NUM_GHR_BITS-1:0]     ghr_q, ghr_d;
  logic [1:0]                  pht_d;

  logic [IDX_W-1:0]        f_idx, e_idx;
  logic [TAG_W-1:0]        f_tag, e_tag;
  logic [NUM_GHR_BITS-1:0] f_pht_idx;
  logic                    f_hit, f_taken, upd_en;
  logic                    unused_pc_bits;

  assign unused_pc_bits = ^{PCF_i[1:0], PCE_i[1:0]};

  // Fetch lookup: reads pre-update table contents, so a same-cycle write is not bypassed.
  assign f_idx     = PCF_i[IDX_W+1:2];
  assign f_tag     = PCF_i[31:IDX_W+2];
  assign f_pht_idx = PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
  assign f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_taken   = reset && f_hit &&
                     (jump_q[f_idx] || (branch_q[f_idx] && pht_q[f_pht_idx][1]));

  assign BranchTakenF_o = f_taken;
  assign BTBtargetF_o   = f_taken ? target_q[f_idx] : 32'h0;
  assign PHTindexF_o    = f_pht_idx;

  assign e_idx  = PCE_i[IDX_W+1:2];
  assign e_tag  = PCE_i[31:IDX_W+2];
  assign upd_en = BranchE_i || JumpE_i;

  always_comb begin
    pht_d = pht_q[PHTindexE_i];
    if (BranchTakenE_i) begin
      if (pht_d != 2'b11) pht_d = pht_d + 2'b01;
    end else begin
      if (pht_d != 2'b00) pht_d = pht_d - 2'b01;
    end
    ghr_d = {ghr_q[NUM_GHR_BITS-2:0], BranchTakenE_i};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      pht_q   <= {PHT_N{2'b01}};
      ghr_q   <= '0;
    end else begin
      if (upd_en) valid_q[e_idx] <= 1'b1;
      if (BranchE_i) begin
        pht_q[PHTindexE_i] <= pht_d;
        ghr_q              <= ghr_d;
      end
    end
  end

  // Entry payload needs no reset; valid_q gates it. Reset still blocks the write.
  always_ff @(posedge clk) begin
    if (reset && upd_en) begin
      tag_q[e_idx]    <= e_tag;
      target_q[e_idx] <= PCTargetE_i;
      jump_q[e_idx]   <= JumpE_i;
      branch_q[e_idx] <= BranchE_i;
    end
  end

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Bench for ucsbece154b_branch_predictor: reference model feeds an expected queue,
// directed scenarios plus randomized training traffic.
module tb_ucsbece154b_branch_predictor;

  localparam int G = 5;

  logic          clk;
  logic          reset;
  logic [31:0]   PCF_i;
  logic          BranchTakenF_o;
  logic [31:0]   BTBtargetF_o;
  logic [G-1:0]  PHTindexF_o;
  logic [31:0]   PCE_i;
  logic [31:0]   PCTargetE_i;
  logic          BranchE_i;
  logic          JumpE_i;
  logic          BranchTakenE_i;
  logic [G-1:0]  PHTindexE_i;

  ucsbece154b_branch_predictor #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(G)) dut (
    .clk(clk), .reset(reset), .PCF_i(PCF_i),
    .BranchTakenF_o(BranchTakenF_o), .BTBtargetF_o(BTBtargetF_o), .PHTindexF_o(PHTindexF_o),
    .PCE_i(PCE_i), .PCTargetE_i(PCTargetE_i), .BranchE_i(BranchE_i), .JumpE_i(JumpE_i),
    .BranchTakenE_i(BranchTakenE_i), .PHTindexE_i(PHTindexE_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic          m_valid [32];
  logic [24:0]   m_tag   [32];
  logic [31:0]   m_tgt   [32];
  logic          m_jmp   [32];
  logic          m_br    [32];
  logic [1:0]    m_pht   [32];
  logic [G-1:0]  m_ghr;

  logic [37:0]   exp_q[$];
  int            n_checks;
  int            n_pass;
  logic          obs_taken;
  logic [31:0]   obs_tgt;
  logic [G-1:0]  obs_idx;
  logic [31:0]   pool [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_pht[i]   = 2'b01;
    end
    m_ghr = '0;
  endtask

  // One fetch/resolve cycle: drive, predict from model, compare, then advance model.
  task automatic cycle(input logic [31:0] pcf, input logic rst_n, input logic br,
                       input logic jp, input logic tk, input logic [31:0] pce,
                       input logic [31:0] tgt, input logic [G-1:0] phte);
    logic [4:0]  bi, ei;
    logic [G-1:0] pi;
    logic        t;
    logic [37:0] e;
    @(posedge clk);
    #1;
    PCF_i = pcf; reset = rst_n; BranchE_i = br; JumpE_i = jp; BranchTakenE_i = tk;
    PCE_i = pce; PCTargetE_i = tgt; PHTindexE_i = phte;
    bi = pcf[6:2];
    pi = pcf[6:2] ^ m_ghr;
    t  = rst_n && m_valid[bi] && (m_tag[bi] == pcf[31:7]) &&
         (m_jmp[bi] || (m_br[bi] && m_pht[pi][1]));
    exp_q.push_back({t, (t ? m_tgt[bi] : 32'h0), pi});
    @(negedge clk);
    obs_taken = BranchTakenF_o;
    obs_tgt   = BTBtargetF_o;
    obs_idx   = PHTindexF_o;
    e = exp_q.pop_front();
    check_val("taken",  {31'h0, obs_taken}, {31'h0, e[37]});
    check_val("target", obs_tgt, e[36:5]);
    check_val("phtidx", {27'h0, obs_idx}, {27'h0, e[4:0]});
    if (!rst_n) model_reset();
    else begin
      if (br || jp) begin
        ei = pce[6:2];
        m_valid[ei] = 1'b1; m_tag[ei] = pce[31:7]; m_tgt[ei] = tgt;
        m_jmp[ei] = jp; m_br[ei] = br;
      end
      if (br) begin
        if (tk && m_pht[phte] != 2'b11) m_pht[phte] = m_pht[phte] + 2'b01;
        else if (!tk && m_pht[phte] != 2'b00) m_pht[phte] = m_pht[phte] - 2'b01;
        m_ghr = {m_ghr[G-2:0], tk};
      end
    end
  endtask

  task automatic idle(input logic [31:0] pcf);
    cycle(pcf, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pool = '{32'h40, 32'hC40, 32'h20, 32'h80, 32'h0C, 32'h70, 32'h200, 32'h1234};
    model_reset();
    reset = 1'b0; PCF_i = '0; PCE_i = '0; PCTargetE_i = '0;
    BranchE_i = 1'b0; JumpE_i = 1'b0; BranchTakenE_i = 1'b0; PHTindexE_i = '0;
    @(posedge clk);

    // reset held, then released
    cycle(32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    idle(32'h10);
    check_val("rst_taken", {31'h0, obs_taken}, 32'h0);
    check_val("rst_tgt", obs_tgt, 32'h0);
    check_val("rst_idx", {27'h0, obs_idx}, 32'h04);

    // jump training and tag mismatch
    cycle(32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h100, '0);
    idle(32'h40);
    check_val("jmp_taken", {31'h0, obs_taken}, 32'h1);
    check_val("jmp_tgt", obs_tgt, 32'h100);
    idle(32'hC40);
    check_val("jmp_tagmiss", {31'h0, obs_taken}, 32'h0);

    // branch hysteresis at PHT index 0x08
    cycle(32'h20, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h8, 5'h08);
    idle(32'h20);
    check_val("hyst_idx1", {27'h0, obs_idx}, 32'h09);
    for (int i = 0; i < 5; i++) cycle(32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h4, 5'h1F);
    idle(32'h20);
    check_val("hyst_taken", {31'h0, obs_taken}, 32'h1);
    check_val("hyst_tgt", obs_tgt, 32'h8);
    cycle(32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h8, 5'h08);
    idle(32'h20);
    check_val("hyst_nt", {31'h0, obs_taken}, 32'h0);

    // saturation at PHT index 3
    for (int i = 0; i < 5; i++) cycle(32'h70, 1'b1, 1'b1, 1'b0, 1'b1, 32'h70, 32'h300, 5'h03);
    idle(32'h70);
    check_val("sat_up", {31'h0, obs_taken}, 32'h1);
    check_val("sat_ghr", {27'h0, obs_idx}, 32'h03);
    for (int i = 0; i < 5; i++) cycle(32'h0C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0C, 32'h400, 5'h03);
    idle(32'h0C);
    check_val("sat_dn", {31'h0, obs_taken}, 32'h0);
    check_val("sat_dn_idx", {27'h0, obs_idx}, 32'h03);
    cycle(32'h0C, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'h400, 5'h03);
    cycle(32'h0C, 1'b1, 1'b1, 1'b0, 1'b1, 32'h70, 32'h300, 5'h03);

    // read/write collision
    cycle(32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h500, '0);
    check_val("coll_same", {31'h0, obs_taken}, 32'h0);
    idle(32'h80);
    check_val("coll_next", {31'h0, obs_taken}, 32'h1);

    // reset during an update
    cycle(32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h100, '0);
    cycle(32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h100, 5'h10);
    check_val("mrst_force", {31'h0, obs_taken}, 32'h0);
    idle(32'h40);
    check_val("mrst_taken", {31'h0, obs_taken}, 32'h0);
    check_val("mrst_idx", {27'h0, obs_idx}, 32'h10);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pcf, pce;
      logic [G-1:0] phte;
      int r;
      pcf = pool[$urandom_range(0, 7)];
      pce = pool[$urandom_range(0, 7)];
      phte = ($urandom_range(0, 1) == 0) ? (pce[6:2] ^ m_ghr) : G'($urandom_range(0, 31));
      r = $urandom_range(0, 9);
      cycle(pcf, ($urandom_range(0, 49) != 0), (r >= 4 && r != 7 && r != 8),
            (r >= 7), $urandom_range(0, 1) == 1, pce,
            {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, phte);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
